// File: rtl/cobra_run_ctrl.sv
// Run/debug controller for the CYBERcobra core: free run, halt, single-step,
// PC breakpoint and a retired-instruction counter driving the core's execute enable.
module cobra_run_ctrl #(
  parameter int PC_W     = 32,
  parameter int CNT_W    = 32,
  parameter int AUTO_RUN = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             halt_i,
  input  logic             step_i,
  input  logic             bp_en_i,
  input  logic [PC_W-1:0]  bp_addr_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             cnt_clr_i,
  output logic             cpu_en_o,
  output logic             halted_o,
  output logic [1:0]       state_o,
  output logic             bp_hit_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    BRK  = 2'b11
  } state_t;

  localparam state_t RESET_STATE = (AUTO_RUN != 0) ? RUN : IDLE;

  state_t           state;
  state_t           state_next;
  logic             skip;
  logic             skip_next;
  logic             bp_hit;
  logic             bp_hit_next;
  logic             cpu_en;
  logic             bp_match;
  logic [CNT_W-1:0] instr_cnt;

  assign bp_match = bp_en_i && (pc_i == bp_addr_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= RESET_STATE;
      skip   <= 1'b0;
      bp_hit <= 1'b0;
    end else begin
      state  <= state_next;
      skip   <= skip_next;
      bp_hit <= bp_hit_next;
    end
  end

  // Pulse priority is halt > step > run; skip lets a resumed run execute the
  // breakpoint instruction once before the breakpoint can fire again.
  always_comb begin
    state_next  = state;
    skip_next   = skip;
    bp_hit_next = 1'b0;
    cpu_en      = 1'b0;
    case (state)
      IDLE: begin
        if (!halt_i) begin
          if (step_i) begin
            state_next = STEP;
          end else if (run_i) begin
            state_next = RUN;
            skip_next  = 1'b0;
          end
        end
      end
      RUN: begin
        cpu_en    = !(bp_match && !skip);
        skip_next = 1'b0;
        if (halt_i) begin
          state_next = IDLE;
        end else if (bp_match && !skip) begin
          state_next  = BRK;
          bp_hit_next = 1'b1;
        end
      end
      STEP: begin
        cpu_en     = 1'b1;
        state_next = IDLE;
      end
      BRK: begin
        if (halt_i) begin
          state_next = IDLE;
        end else if (step_i) begin
          state_next = STEP;
        end else if (run_i) begin
          state_next = RUN;
          skip_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_cnt <= '0;
    end else if (cnt_clr_i) begin
      instr_cnt <= '0;
    end else if (cpu_en) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  // Gating with reset removes the enable immediately, even from an AUTO_RUN reset state.
  assign cpu_en_o    = cpu_en && rst_i;
  assign halted_o    = (state == IDLE) || (state == BRK);
  assign state_o     = state;
  assign bp_hit_o    = bp_hit;
  assign instr_cnt_o = instr_cnt;

endmodule

// File: tb/tb_cobra_run_ctrl.sv
// Self-checking bench for cobra_run_ctrl: directed scenarios plus randomized pulses,
// checked every cycle against a behavioural model for an AUTO_RUN=0 and an AUTO_RUN=1 instance.
module tb_cobra_run_ctrl;

  localparam int PC_W = 32;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_BRK  = 2'b11;
  localparam longint unsigned M32 = 64'hFFFF_FFFF;
  localparam longint unsigned M8  = 64'hFF;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic run_i = 1'b0, halt_i = 1'b0, step_i = 1'b0, bp_en_i = 1'b0, cnt_clr_i = 1'b0;
  logic [PC_W-1:0] bp_addr_i = '0;
  logic [PC_W-1:0] pc_i = '0;

  logic        a_cpu_en, a_halted, a_bp_hit;
  logic [1:0]  a_state;
  logic [31:0] a_cnt;
  logic        b_cpu_en, b_halted, b_bp_hit;
  logic [1:0]  b_state;
  logic [7:0]  b_cnt;

  int checkCount = 0;
  int errCount   = 0;
  int enSeen     = 0;
  int hitSeen    = 0;

  always #5 clk_i = ~clk_i;

  cobra_run_ctrl #(.PC_W(PC_W), .CNT_W(32), .AUTO_RUN(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .halt_i(halt_i), .step_i(step_i),
    .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .pc_i(pc_i), .cnt_clr_i(cnt_clr_i),
    .cpu_en_o(a_cpu_en), .halted_o(a_halted), .state_o(a_state), .bp_hit_o(a_bp_hit),
    .instr_cnt_o(a_cnt)
  );

  // Narrow counter so wraparound is reachable in a short run.
  cobra_run_ctrl #(.PC_W(PC_W), .CNT_W(8), .AUTO_RUN(1)) dut_auto (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .halt_i(halt_i), .step_i(step_i),
    .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .pc_i(pc_i), .cnt_clr_i(cnt_clr_i),
    .cpu_en_o(b_cpu_en), .halted_o(b_halted), .state_o(b_state), .bp_hit_o(b_bp_hit),
    .instr_cnt_o(b_cnt)
  );

  typedef struct {
    logic [1:0]      st;
    bit              skip;
    bit              hit;
    longint unsigned cnt;
    longint unsigned mask;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset(bit auto_run, longint unsigned mask);
    model_t m;
    m.st   = auto_run ? S_RUN : S_IDLE;
    m.skip = 1'b0;
    m.hit  = 1'b0;
    m.cnt  = 0;
    m.mask = mask;
    return m;
  endfunction

  function automatic bit model_en(model_t m, bit rst, bit match);
    if (!rst) return 1'b0;
    if (m.st == S_STEP) return 1'b1;
    if (m.st == S_RUN) return !(match && !m.skip);
    return 1'b0;
  endfunction

  function automatic model_t model_next(model_t m, bit en, bit h, bit s, bit r, bit c, bit match);
    model_t n;
    int cmd;
    n = m;
    cmd = h ? 3 : (s ? 2 : (r ? 1 : 0));
    if (c) n.cnt = 0;
    else if (en) n.cnt = (m.cnt + 1) & m.mask;
    if (m.st == S_IDLE) begin
      if (cmd == 2) n.st = S_STEP;
      else if (cmd == 1) begin n.st = S_RUN; n.skip = 1'b0; end
    end else if (m.st == S_RUN) begin
      n.skip = 1'b0;
      if (cmd == 3) n.st = S_IDLE;
      else if (match && !m.skip) n.st = S_BRK;
    end else if (m.st == S_STEP) begin
      n.st = S_IDLE;
    end else begin
      if (cmd == 3) n.st = S_IDLE;
      else if (cmd == 2) n.st = S_STEP;
      else if (cmd == 1) begin n.st = S_RUN; n.skip = 1'b1; end
    end
    n.hit = (n.st == S_BRK) && (m.st != S_BRK);
    return n;
  endfunction

  task automatic checkOutput(input string tag, input longint unsigned act, input longint unsigned exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic compareAll(input bit ea, input bit eb);
    checkOutput("a_cpu_en", a_cpu_en, ea);
    checkOutput("a_state", a_state, ma.st);
    checkOutput("a_halted", a_halted, (ma.st == S_IDLE) || (ma.st == S_BRK));
    checkOutput("a_bp_hit", a_bp_hit, ma.hit);
    checkOutput("a_cnt", a_cnt, ma.cnt);
    checkOutput("b_cpu_en", b_cpu_en, eb);
    checkOutput("b_state", b_state, mb.st);
    checkOutput("b_halted", b_halted, (mb.st == S_IDLE) || (mb.st == S_BRK));
    checkOutput("b_bp_hit", b_bp_hit, mb.hit);
    checkOutput("b_cnt", b_cnt, mb.cnt);
  endtask

  // One clock cycle: drive pulses at the falling edge, check, advance model, step core PC.
  task automatic applyStimulus(input bit h, input bit s, input bit r, input bit c);
    bit match, ea, eb;
    halt_i = h; step_i = s; run_i = r; cnt_clr_i = c;
    #1;
    match = bp_en_i && (pc_i == bp_addr_i);
    ea = model_en(ma, rst_i, match);
    eb = model_en(mb, rst_i, match);
    compareAll(ea, eb);
    if (a_cpu_en === 1'b1) enSeen++;
    if (a_bp_hit === 1'b1) hitSeen++;
    ma = model_next(ma, ea, h, s, r, c, match);
    mb = model_next(mb, eb, h, s, r, c, match);
    @(negedge clk_i);
    halt_i = 1'b0; step_i = 1'b0; run_i = 1'b0; cnt_clr_i = 1'b0;
    if (ea) pc_i = pc_i + 32'd4;
  endtask

  // Reset pulse placed between clock edges, checked while asserted.
  task automatic asyncReset();
    #2 rst_i = 1'b0;
    #1;
    ma = model_reset(1'b0, M32);
    mb = model_reset(1'b1, M8);
    checkOutput("rst_a_cpu_en", a_cpu_en, 0);
    checkOutput("rst_a_cnt", a_cnt, 0);
    checkOutput("rst_a_state", a_state, S_IDLE);
    checkOutput("rst_a_bp_hit", a_bp_hit, 0);
    checkOutput("rst_b_cpu_en", b_cpu_en, 0);
    checkOutput("rst_b_state", b_state, S_RUN);
    checkOutput("rst_b_cnt", b_cnt, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    asyncReset();

    // Run pulse at cycle 3, halt at cycle 13: ten executed instructions.
    enSeen = 0;
    for (int c = 0; c < 14; c++) applyStimulus(c == 13, 1'b0, c == 3, 1'b0);
    #1;
    checkOutput("s1_cnt", a_cnt, 10);
    checkOutput("s1_en_cycles", enSeen, 10);
    checkOutput("s1_state", a_state, S_IDLE);
    checkOutput("s1_halted", a_halted, 1);

    // Three single steps from IDLE.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    enSeen = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      #1 checkOutput("s2_step_en", a_cpu_en, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      #1 checkOutput("s2_state", a_state, S_IDLE);
    end
    checkOutput("s2_cnt", a_cnt, 3);
    checkOutput("s2_en_cycles", enSeen, 3);

    // Breakpoint at 0x10 while the PC walks up from 0.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    pc_i = '0; bp_en_i = 1'b1; bp_addr_i = 32'h10;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("s3_bp_blocked", a_cpu_en, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("s3_state", a_state, S_BRK);
    checkOutput("s3_bp_hit", a_bp_hit, 1);
    checkOutput("s3_cnt", a_cnt, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("s3_bp_hit_once", a_bp_hit, 0);

    // Resume: the breakpoint instruction executes once, no re-trigger until PC returns.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("s4_exec_bp", a_cpu_en, 1);
    hitSeen = 0;
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s4_no_rehit", hitSeen, 0);
    checkOutput("s4_pc_moved", pc_i, 32'h28);
    pc_i = 32'h10;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("s4_rehit_state", a_state, S_BRK);
    checkOutput("s4_rehit_pulse", a_bp_hit, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    bp_en_i = 1'b0;

    // Coincident pulses in IDLE, then clear during an executing step.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("s5_prio_state", a_state, S_IDLE);
    checkOutput("s5_prio_en", a_cpu_en, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    #1 checkOutput("s5_clr_over_inc", a_cnt, 0);

    // Reset mid-run, then AUTO_RUN instance runs from the first cycle and wraps its counter.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    asyncReset();
    #1;
    checkOutput("s6_auto_state", b_state, S_RUN);
    checkOutput("s6_auto_en", b_cpu_en, 1);
    repeat (255) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("s6_cnt_max", b_cnt, 8'hFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("s6_cnt_wrap", b_cnt, 0);

    // Randomized pulses, breakpoints, PC jumps and occasional async resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(399) == 0) asyncReset();
      if ($urandom_range(15) == 0) bp_en_i = ~bp_en_i;
      if ($urandom_range(31) == 0) bp_addr_i = 32'($urandom_range(15)) << 2;
      if ($urandom_range(11) == 0) pc_i = 32'($urandom_range(15)) << 2;
      applyStimulus($urandom_range(13) == 0, $urandom_range(9) == 0,
                    $urandom_range(5) == 0, $urandom_range(31) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cobra_run_ctrl.md
Name: cobra_run_ctrl

Overview:
Run/debug controller for the CYBERcobra core. Sequences execution by generating the core's per-cycle execute enable. Supports free run, halt, single-step and a PC breakpoint, and counts retired instructions. Sits between the board buttons/switch logic and the core's clock-enable input, and observes the core's PC.

Parameters:
PC_W, 32, width of program counter and breakpoint address
CNT_W, 32, width of retired-instruction counter
AUTO_RUN, 0, 1 = leave reset in RUN, 0 = leave reset in IDLE

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous, active-low reset
run_i  in  1  one-cycle pulse: start/resume free run
halt_i  in  1  one-cycle pulse: stop execution
step_i  in  1  one-cycle pulse: execute exactly one instruction
bp_en_i  in  1  breakpoint enable, level
bp_addr_i  in  PC_W  breakpoint address
pc_i  in  PC_W  current core PC (address of instruction about to execute)
cnt_clr_i  in  1  synchronous clear of instruction counter
cpu_en_o  out  1  core execute enable for this cycle (combinational from state/flags)
halted_o  out  1  1 in IDLE or BRK
state_o  out  2  IDLE=00, RUN=01, STEP=10, BRK=11
bp_hit_o  out  1  registered one-cycle pulse on entry to BRK
instr_cnt_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_i=0, async): state = RUN if AUTO_RUN else IDLE; instr_cnt_o=0; bp_hit_o=0; skip flag=0.
- cpu_en_o is derived from the current state and flags, not registered:
  - 1 in STEP.
  - 1 in RUN unless bp_match && !skip.
  - 0 in IDLE and BRK.
- bp_match = bp_en_i && (pc_i == bp_addr_i).
- Input priority when pulses coincide: halt_i > step_i > run_i.
- IDLE transitions:
  - halt_i: stay IDLE.
  - step_i: go to STEP.
  - run_i: go to RUN, skip=0.
- RUN transitions:
  - halt_i: go to IDLE. The instruction in that cycle still executes if cpu_en_o=1.
  - Else bp_match && !skip: go to BRK, bp_hit_o=1 next cycle. The breakpoint instruction is NOT executed.
  - step_i and run_i are ignored.
  - skip is cleared after the first RUN cycle.
- STEP lasts exactly one cycle with cpu_en_o=1, ignoring breakpoints; then go to IDLE. Pulses arriving during STEP are ignored.
- BRK transitions:
  - halt_i: go to IDLE.
  - step_i: go to STEP. Executes the breakpoint instruction.
  - run_i: go to RUN with skip=1, so the breakpoint instruction executes once. It re-triggers only when the PC returns to bp_addr_i later.
- bp_hit_o is high for exactly one cycle per BRK entry and is 0 otherwise.
- instr_cnt_o increments by 1 in every cycle with cpu_en_o=1 and wraps from 2^CNT_W-1 to 0.
  - cnt_clr_i has priority over increment (result 0).
- Reset asserted mid-RUN/STEP: cpu_en_o drops to 0 immediately (async) and all state is reinitialised.
- bp_en_i deasserted while in BRK: stay in BRK until a pulse arrives.

Test Plan:
1. Reset release with AUTO_RUN=0, then run_i pulse at cycle 3; halt_i pulse at cycle 13 -> cpu_en_o=1 for cycles 4..13; instr_cnt_o=10; state_o=00; halted_o=1.
2. From IDLE, three step_i pulses 4 cycles apart -> three single-cycle cpu_en_o pulses; instr_cnt_o=3; state returns to 00 after each step.
3. bp_en_i=1, bp_addr_i=0x10, run while pc_i counts 0x00,0x04,... -> cpu_en_o=0 when pc_i=0x10; state_o=11; bp_hit_o one-cycle pulse; instr_cnt_o=4.
4. From BRK in scenario 3, run_i -> instruction at 0x10 executes (cpu_en_o=1); core continues to 0x14; no second bp_hit_o until pc_i=0x10 again.
5. Same cycle halt_i=1, step_i=1, run_i=1 in IDLE -> stay IDLE, cpu_en_o=0. Preload counter to 0xFFFFFFFF via run, then one step -> instr_cnt_o wraps to 0. cnt_clr_i together with an executing step -> instr_cnt_o=0.
6. rst_i driven low mid-RUN (not on a clock edge) -> cpu_en_o=0, instr_cnt_o=0, state_o=00 immediately. With AUTO_RUN=1, release -> state_o=01 and cpu_en_o=1 on the first cycle.
